// File: rtl/alu_loader_pkg.sv
// Shared types and constants for the ALU operand loader.
// State encodings double as the state_dbg output values.
package alu_loader_pkg;

    localparam int BYTE_W             = 8;
    localparam int DEF_OPCODE_W       = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        S_A     = 2'd0,
        S_B     = 2'd1,
        S_OP    = 2'd2,
        S_ISSUE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_loader_timer.sv
// Inter-byte watchdog counter for the operand loader.
// expire flags the last permitted idle cycle of a partial frame.
module alu_loader_timer
    import alu_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expire
);

    logic [BYTE_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + 8'd1;
        end
    end

    assign expire = (count == BYTE_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_operand_loader.sv
// Assembles A, B, opcode bytes into one ALU command with a
// valid/ready handshake, abort/timeout recovery and an issue counter.
module alu_operand_loader
    import alu_loader_pkg::*;
#(
    parameter int OPCODE_W       = DEF_OPCODE_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [BYTE_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                abort,
    output logic [BYTE_W-1:0]   op_a,
    output logic [BYTE_W-1:0]   op_b,
    output logic [OPCODE_W-1:0] opcode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                frame_err,
    output logic                timeout,
    output logic [BYTE_W-1:0]   frame_count,
    output logic [1:0]          state_dbg
);

    state_t state, state_nxt;
    logic   accept, xfer, run, expire, tmo, bad_op;
    logic   ld_a, ld_b, ld_op, err;

    assign in_ready  = ena & (state != S_ISSUE);
    assign accept    = in_valid & in_ready;
    assign xfer      = ena & out_ready & (state == S_ISSUE);
    assign run       = ena & ((state == S_B) | (state == S_OP));
    assign bad_op    = (in_data >> OPCODE_W) != '0;
    // A byte landing on the expiry edge wins over the watchdog.
    assign tmo       = run & expire & ~accept & ~abort;
    assign state_dbg = state;

    alu_loader_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .clear (abort | accept | tmo),
        .expire(expire)
    );

    always_comb begin
        state_nxt = state;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_op     = 1'b0;
        err       = 1'b0;
        if (abort) begin
            state_nxt = S_A;
        end else if (accept) begin
            unique case (state)
                S_A: begin
                    ld_a      = 1'b1;
                    state_nxt = S_B;
                end
                S_B: begin
                    ld_b      = 1'b1;
                    state_nxt = S_OP;
                end
                S_OP: begin
                    if (bad_op) begin
                        err       = 1'b1;
                        state_nxt = S_A;
                    end else begin
                        ld_op     = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
                default: state_nxt = state;
            endcase
        end else if (xfer || tmo) begin
            state_nxt = S_A;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_A;
            op_a        <= '0;
            op_b        <= '0;
            opcode      <= '0;
            out_valid   <= 1'b0;
            frame_err   <= 1'b0;
            timeout     <= 1'b0;
            frame_count <= '0;
        end else begin
            state     <= state_nxt;
            frame_err <= err;
            timeout   <= tmo;
            if (ld_a) op_a <= in_data;
            if (ld_b) op_b <= in_data;
            if (ld_op) opcode <= in_data[OPCODE_W-1:0];
            if (abort) begin
                out_valid <= 1'b0;
            end else if (ld_op) begin
                out_valid <= 1'b1;
            end else if (xfer) begin
                out_valid   <= 1'b0;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader against a
// byte-queue reference model, using a short watchdog limit.
module tb_alu_operand_loader;
    import alu_loader_pkg::*;

    localparam int OPW = 4;
    localparam int TMO = 5;

    logic       clk = 1'b0;
    logic       rst, ena, in_valid, abort, out_ready;
    logic       in_ready, out_valid, frame_err, timeout;
    logic [7:0] in_data, op_a, op_b, frame_count;
    logic [3:0] opcode;
    logic [1:0] state_dbg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_operand_loader #(
        .OPCODE_W(OPW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .abort(abort),
        .op_a(op_a), .op_b(op_b), .opcode(opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .frame_err(frame_err), .timeout(timeout),
        .frame_count(frame_count), .state_dbg(state_dbg)
    );

    // Reference model: bytes of the partial frame, pending command.
    logic [7:0] m_bytes[$];
    logic       m_pend, m_err, m_tmo;
    logic [7:0] m_a, m_b;
    logic [3:0] m_op;
    int         m_cnt, m_idle;

    wire [33:0] obs = {out_valid, in_ready, frame_err, timeout,
                       state_dbg, frame_count,
                       out_valid ? {op_a, op_b, opcode} : 20'h0};

    function automatic logic [33:0] exp_vec();
        logic [1:0] st;
        st = m_pend ? 2'd3 : 2'(m_bytes.size());
        return {m_pend, ena & ~m_pend, m_err, m_tmo, st,
                8'(m_cnt), m_pend ? {m_a, m_b, m_op} : 20'h0};
    endfunction

    task automatic tick();
        @(posedge clk);
        m_err = 1'b0;
        m_tmo = 1'b0;
        if (rst) begin
            m_bytes.delete();
            m_pend = 1'b0;
            m_cnt  = 0;
            m_idle = 0;
            m_a    = '0;
            m_b    = '0;
            m_op   = '0;
        end else if (abort) begin
            m_bytes.delete();
            m_pend = 1'b0;
            m_idle = 0;
        end else if (ena && !m_pend && in_valid) begin
            m_idle = 0;
            m_bytes.push_back(in_data);
            if (m_bytes.size() == 3) begin
                if ((m_bytes[2] >> OPW) != 0) begin
                    m_err = 1'b1;
                end else begin
                    m_a    = m_bytes[0];
                    m_b    = m_bytes[1];
                    m_op   = m_bytes[2][3:0];
                    m_pend = 1'b1;
                end
                m_bytes.delete();
            end
        end else if (ena && m_pend && out_ready) begin
            m_pend = 1'b0;
            m_cnt  = (m_cnt + 1) % 256;
        end else if (ena && m_bytes.size() > 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                m_tmo = 1'b1;
                m_idle = 0;
                m_bytes.delete();
            end
        end
        #1;
    endtask

    task automatic drv(input logic v, input logic [7:0] d,
                       input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; abort = 1'b0;
        drv(1'b1, 8'hFF, 1'b1);
        tick();
        tick();
        total++;
        if (obs !== {2'b01, 32'h0}) begin
            bad++;
            $display("FAIL reset obs: got %h want %h", obs, {2'b01, 32'h0});
        end
        total++;
        if ({op_a, op_b, opcode} !== 20'h0) begin
            bad++;
            $display("FAIL reset regs: got %h want 0", {op_a, op_b, opcode});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        logic [7:0] seq [3] = '{8'h12, 8'h34, 8'h03};
        int nv = 0;
        for (int i = 0; i < 5; i++) begin
            drv(i < 3, i < 3 ? seq[i] : 8'h00, 1'b1);
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL basic cyc%0d: got %h want %h", i, obs, exp_vec());
            end
            if (out_valid) begin
                nv++;
                total++;
                if ({op_a, op_b, opcode, in_ready} !== {8'h12, 8'h34, 4'h3, 1'b0}) begin
                    bad++;
                    $display("FAIL basic cmd: got %h want 1234_3_0", {op_a, op_b, opcode, in_ready});
                end
            end
        end
        total++;
        if (nv !== 1 || frame_count !== 8'd1) begin
            bad++;
            $display("FAIL basic count: got v=%0d fc=%0d want v=1 fc=1", nv, frame_count);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] seq [3] = '{8'h12, 8'h34, 8'h03};
        logic [7:0] fc0;
        int nv = 0, nt = 0;
        fc0 = frame_count;
        for (int i = 0; i < 14; i++) begin
            if (i < 3) drv(1'b1, seq[i], 1'b0);
            else drv(1'($urandom_range(1)), 8'($urandom), i == 13);
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL bp cyc%0d: got %h want %h", i, obs, exp_vec());
            end
            if (timeout) nt++;
            if (out_valid) nv++;
            if (out_valid) begin
                total++;
                if ({op_a, op_b, opcode} !== {8'h12, 8'h34, 4'h3}) begin
                    bad++;
                    $display("FAIL bp hold: got %h want 12343", {op_a, op_b, opcode});
                end
            end
        end
        total++;
        if (nv !== 11 || nt !== 0 || frame_count !== fc0 + 8'd1) begin
            bad++;
            $display("FAIL bp summary: got v=%0d t=%0d fc=%0d want 11 0 %0d", nv, nt, frame_count, fc0 + 8'd1);
        end
        drv(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_bad_opcode();
        logic [7:0] seq [6] = '{8'hAA, 8'h55, 8'h93, 8'h01, 8'h02, 8'h04};
        int ne = 0, nv = 0;
        for (int i = 0; i < 8; i++) begin
            drv(i < 6, i < 6 ? seq[i] : 8'h00, 1'b1);
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL badop cyc%0d: got %h want %h", i, obs, exp_vec());
            end
            if (frame_err) ne++;
            if (i == 2) begin
                total++;
                if ({frame_err, out_valid, state_dbg} !== 4'b1000) begin
                    bad++;
                    $display("FAIL badop reject: got %b want 1000", {frame_err, out_valid, state_dbg});
                end
            end
            if (out_valid) begin
                nv++;
                total++;
                if ({op_a, op_b, opcode} !== {8'h01, 8'h02, 4'h4}) begin
                    bad++;
                    $display("FAIL badop good: got %h want 01024", {op_a, op_b, opcode});
                end
            end
        end
        total++;
        if (ne !== 1 || nv !== 1) begin
            bad++;
            $display("FAIL badop counts: got e=%0d v=%0d want 1 1", ne, nv);
        end
    endtask

    task automatic test_timeout();
        int nt = 0;
        drv(1'b1, 8'h10, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            drv(1'b0, 8'h00, 1'b1);
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL tmo cyc%0d: got %h want %h", i, obs, exp_vec());
            end
            if (timeout) nt++;
        end
        total++;
        if (nt !== 1 || timeout !== 1'b1 || state_dbg !== 2'd0) begin
            bad++;
            $display("FAIL tmo fire: got n=%0d t=%b st=%0d want 1 1 0", nt, timeout, state_dbg);
        end
        nt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) drv(1'b1, 8'h10, 1'b1);
            else if (i == 5) drv(1'b1, 8'h20, 1'b1);
            else if (i == 6) drv(1'b1, 8'h05, 1'b1);
            else drv(1'b0, 8'h00, 1'b1);
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL tmo4 cyc%0d: got %h want %h", i, obs, exp_vec());
            end
            if (timeout) nt++;
            if (i == 5) begin
                total++;
                if (state_dbg !== 2'd2) begin
                    bad++;
                    $display("FAIL tmo4 state: got %0d want 2", state_dbg);
                end
            end
        end
        total++;
        if (nt !== 0) begin
            bad++;
            $display("FAIL tmo4 none: got %0d pulses want 0", nt);
        end
    endtask

    task automatic test_abort_ena();
        int np = 0;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 8'(8'h40 + i), 1'b1);
            abort = (i == 2);
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL abort cyc%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        abort = 1'b0;
        total++;
        if ({state_dbg, frame_err, timeout, out_valid} !== 5'b0) begin
            bad++;
            $display("FAIL abort result: got %b want 00000", {state_dbg, frame_err, timeout, out_valid});
        end
        drv(1'b1, 8'h07, 1'b1);
        tick();
        for (int i = 0; i < 20; i++) begin
            ena = 1'b0;
            drv(1'b1, 8'($urandom), 1'b1);
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL ena0 cyc%0d: got %h want %h", i, obs, exp_vec());
            end
            if (timeout) np++;
        end
        ena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv(i < 2, i == 0 ? 8'h08 : 8'h09, 1'b0);
            tick();
            if (timeout) np++;
        end
        total++;
        if (np !== 0 || out_valid !== 1'b1 || {op_a, op_b, opcode} !== {8'h07, 8'h08, 4'h9}) begin
            bad++;
            $display("FAIL ena resume: got t=%0d v=%b cmd=%h want 0 1 07089", np, out_valid, {op_a, op_b, opcode});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({obs, op_a, op_b, opcode} !== {2'b01, 32'h0, 20'h0}) begin
            bad++;
            $display("FAIL rst issue: got %h want %h", {obs, op_a, op_b, opcode}, {2'b01, 32'h0, 20'h0});
        end
    endtask

    task automatic test_wrap();
        int nv = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int f = 0; f < 256; f++) begin
            for (int j = 0; j < 4; j++) begin
                if (j < 2) drv(1'b1, 8'($urandom), 1'b1);
                else if (j == 2) drv(1'b1, 8'($urandom_range(15)), 1'b1);
                else drv(1'b0, 8'h00, 1'b1);
                tick();
                total++;
                if (obs !== exp_vec()) begin
                    bad++;
                    $display("FAIL wrap f%0d c%0d: got %h want %h", f, j, obs, exp_vec());
                end
                if (out_valid) nv++;
            end
        end
        total++;
        if (nv !== 256 || frame_count !== 8'd0) begin
            bad++;
            $display("FAIL wrap end: got v=%0d fc=%0d want 256 0", nv, frame_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            ena   = ($urandom_range(7) != 0);
            abort = ($urandom_range(39) == 0);
            in_valid  = (i < 1500) ? ($urandom_range(3) != 0)
                                   : ($urandom_range(2) == 0);
            in_data   = ($urandom_range(9) < 7) ? 8'($urandom_range(15))
                                                : 8'($urandom);
            out_ready = ($urandom_range(2) != 0);
            tick();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL rand cyc%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        abort = 1'b0;
        ena   = 1'b1;
    endtask

    initial begin
        m_pend = 1'b0;
        m_err  = 1'b0;
        m_tmo  = 1'b0;
        m_cnt  = 0;
        m_idle = 0;
        #2;
        test_reset();
        test_basic_frame();
        test_backpressure();
        test_bad_opcode();
        test_timeout();
        test_abort_ena();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
